// File: rtl/ecc_scrub_pkg_6.sv
// Shared types and constants for the background ECC scrubber.
package ecc_scrub_pkg_6;

  // Geometry of the protected word as seen by the corrector.
  localparam int ECC_DATA_W = 26;
  localparam int ECC_CHK_W  = 5;

  // Scrub sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4
  } scrub_state_t;

endpackage

// File: rtl/ecc_scrubber_6_sat_counter.sv
// Saturating event counter with a synchronous clear that beats increment.
module scrub_sat_counter
  import ecc_scrub_pkg_6::*;
#(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ecc_scrubber_6.sv
// Background scrub controller: walks the bank, writes back corrected words,
// counts correctable/uncorrectable events and logs the first bad address.
module ecc_scrubber_6
  import ecc_scrub_pkg_6::*;
#(
  parameter int DATA_W   = ECC_DATA_W,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              host_busy,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_raw_data,
  input  logic [DATA_W-1:0] mem_corr_data,
  input  logic              mem_uncorr,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              err_clr,
  output logic              pass_done
);

  // Timer only needs to reach INTERVAL-1; keep at least one bit.
  localparam int                TMR_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  scrub_state_t       r_state;
  scrub_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_ptr;
  logic [TMR_W-1:0]   r_timer;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_err_valid;
  logic [ADDR_W-1:0]  r_err_addr;

  logic w_rd_en;
  logic w_wr_en;
  logic w_timer_inc;
  logic w_timer_clr;
  logic w_ptr_step;
  logic w_latch;
  logic w_corr_inc;
  logic w_uncorr_inc;
  logic w_capture;
  logic w_pass_done;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control decode. Strobes are gated by host_busy in the
  // same cycle so the scrubber never collides with a host access; dropping
  // enable outside IDLE abandons the current word and restarts the wait.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_timer_inc  = 1'b0;
    w_timer_clr  = 1'b0;
    w_ptr_step   = 1'b0;
    w_latch      = 1'b0;
    w_corr_inc   = 1'b0;
    w_uncorr_inc = 1'b0;
    w_capture    = 1'b0;
    w_pass_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          if (r_timer == TMR_LAST) begin
            w_timer_clr  = 1'b1;
            w_state_next = ST_READ;
          end else begin
            w_timer_inc = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!enable) begin
          w_timer_clr  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (!host_busy) begin
          w_rd_en      = 1'b1;
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!enable) begin
          w_timer_clr  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (mem_uncorr) begin
          w_uncorr_inc = 1'b1;
          w_capture    = 1'b1;
          w_state_next = ST_NEXT;
        end else if (mem_raw_data != mem_corr_data) begin
          w_corr_inc   = 1'b1;
          w_latch      = 1'b1;
          w_state_next = ST_WRITE;
        end else begin
          w_state_next = ST_NEXT;
        end
      end
      ST_WRITE: begin
        if (!enable) begin
          w_timer_clr  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (!host_busy) begin
          w_wr_en      = 1'b1;
          w_state_next = ST_NEXT;
        end else begin
          // Host may have rewritten the word: latched data is stale, re-read.
          w_state_next = ST_READ;
        end
      end
      ST_NEXT: begin
        if (!enable) begin
          w_timer_clr  = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_ptr_step   = 1'b1;
          w_pass_done  = (r_ptr == PTR_LAST);
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Inter-scrub interval timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else if (w_timer_inc) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Address pointer, wrapping after the last scrubbed word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_ptr_step) begin
      r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  // Corrected-word holding register for the write-back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_data <= '0;
    end else if (w_latch) begin
      r_wr_data <= mem_corr_data;
    end
  end

  // First-uncorrectable log; a coincident clear drops the new event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_capture && !r_err_valid) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= r_ptr;
    end
  end

  scrub_sat_counter #(.W(CNT_W)) u_corr_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_corr_inc),
    .i_clr   (err_clr),
    .o_count (corr_count)
  );

  scrub_sat_counter #(.W(CNT_W)) u_uncorr_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_uncorr_inc),
    .i_clr   (err_clr),
    .o_count (uncorr_count)
  );

  assign mem_rd_en   = w_rd_en;
  assign mem_wr_en   = w_wr_en;
  assign mem_addr    = r_ptr;
  assign mem_wr_data = r_wr_data;
  assign err_valid   = r_err_valid;
  assign err_addr    = r_err_addr;
  assign pass_done   = w_pass_done;

endmodule

// File: doc/ecc_scrubber_6.md
Name: ecc_scrubber_6

Overview:
- Background scrub controller for a bank of 26-bit SECDED-protected words, built from the width-6 ECC memory words (26 data, 5 check, 1 parity).
- Sits directly downstream of the bank's corrector outputs.
- Periodically walks every address, reads raw and corrected data, and writes corrected data back when they differ, so single-bit upsets are removed before they pair into double errors.
- Counts correctable and uncorrectable events, and logs the first uncorrectable address for software.

Parameters:
- DATA_W, 26, data word width; must match the corrector.
- ADDR_W, 6, address width of the bank.
- DEPTH, 64, number of words scrubbed; must be ≤ 2**ADDR_W and ≥ 1.
- INTERVAL, 1024, idle cycles between word scrubs; must be ≥ 1.
- CNT_W, 16, width of the event counters.

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: scrubbing allowed.
- host_busy, input, 1: host owns the bank this cycle; the scrubber must not issue.
- mem_rd_en, output, 1: read strobe.
- mem_wr_en, output, 1: write-back strobe.
- mem_addr, output, ADDR_W: address for the read or write.
- mem_wr_data, output, DATA_W: corrected word to write; drives the checker input.
- mem_raw_data, input, DATA_W: uncorrected stored data.
- mem_corr_data, input, DATA_W: corrector output.
- mem_uncorr, input, 1: corrector error flag (double error).
- corr_count, output, CNT_W: correctable events, saturating.
- uncorr_count, output, CNT_W: uncorrectable events, saturating.
- err_valid, output, 1: sticky, first uncorrectable address captured.
- err_addr, output, ADDR_W: first uncorrectable address.
- err_clr, input, 1: clears err_valid, err_addr and both counters.
- pass_done, output, 1: one-cycle pulse after the last address is processed.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; address pointer and interval timer are 0.
  - All outputs are 0.
- Bank read latency is 1 cycle: a read strobed in cycle t returns mem_raw_data, mem_corr_data and mem_uncorr valid in cycle t+1.
- Write-back takes effect at the next edge.
- FSM states: IDLE, READ, CHECK, WRITE, NEXT.
- IDLE:
  - Timer increments each cycle while enable is 1.
  - When timer = INTERVAL-1: clear the timer and go to READ.
  - enable = 0 holds the timer at its current value.
- READ:
  - If host_busy = 0: assert mem_rd_en with mem_addr = pointer, then go to CHECK.
  - Otherwise stay in READ with strobes low.
- CHECK (samples the bank outputs):
  - mem_uncorr = 1: increment uncorr_count. If err_valid = 0, set it and capture err_addr = pointer. Go to NEXT; no write-back.
  - raw ≠ corrected: increment corr_count, latch the corrected word, go to WRITE.
  - Otherwise go to NEXT.
- WRITE:
  - If host_busy = 0: assert mem_wr_en with mem_wr_data = latched word and mem_addr = pointer, then go to NEXT.
  - If host_busy = 1: abandon the write-back and return to READ at the same address. The host may have written the word, so the latched data is stale. The corr_count increment stands.
- NEXT:
  - Pointer increments.
  - If pointer was DEPTH-1: wrap to 0 and pulse pass_done.
  - Return to IDLE.
- enable deasserted in any non-IDLE state: return to IDLE next cycle, no strobes, pointer retained, timer reset to 0.
- Strobes:
  - mem_rd_en and mem_wr_en are never high in the same cycle.
  - Neither strobe is ever asserted while host_busy is 1.
- Counters saturate at all-ones.
- err_clr:
  - Has priority over a same-cycle increment or capture, and does not affect the FSM.
  - When err_clr and a new uncorrectable event coincide, the event is lost.
- Single error in a check or parity bit only: raw = corrected, so no write-back occurs. This is accepted behaviour.

Decomposition:
- Package ecc_scrub_pkg_6 holds:
  - The state enum scrub_state_t.
  - Constants ECC_DATA_W = 26, ECC_CHK_W = 5.
- One sub-module, scrub_sat_counter: saturating counter with increment and clear inputs.
  - Instantiated twice, once for corr_count and once for uncorr_count.

Test Plan:
1. INTERVAL = 4, DEPTH = 4, clean bank, enable held high:
   - Reads at addresses 0, 1, 2, 3 with no writes.
   - pass_done pulses once, after the address-3 CHECK cycle.
   - Counters stay 0.
2. Address 2 returns raw 0x0000001 and corrected 0x0000000:
   - One write of 0x0000000 to address 2.
   - corr_count = 1.
3. mem_uncorr = 1 at address 1, then again at address 3:
   - uncorr_count = 2, err_valid = 1, err_addr = 1, no writes.
   - Pulse err_clr: all four cleared.
4. Correctable word at address 0, with host_busy high in the WRITE cycle:
   - No mem_wr_en that cycle; next strobe is mem_rd_en at address 0.
   - Final corr_count = 2 after the successful retry.
5. reset_n low mid-WRITE, asynchronously:
   - Outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the first read occurs at address 0 after INTERVAL cycles.
6. corr_count preloaded near 0xFFFF via repeated errors:
   - Count saturates at 0xFFFF and does not wrap.
